// File: rtl/path_pkg.sv
// Shared path-record layout: 15 slots of 7 bits {marker, ticks[3:0], M2, M1}, newest in slot 0.
package path_pkg;

    localparam int SLOT_W     = 7;
    localparam int SLOT_COUNT = 15;
    localparam int PATH_W     = SLOT_W * SLOT_COUNT;
    localparam int MOT_LSB    = 0;
    localparam int TICK_LSB   = 2;
    localparam int MARK_BIT   = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LAST,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       marker;
        logic [3:0] ticks;
        logic       m2;
        logic       m1;
    } slot_t;

    // Out-of-range indices return an empty slot so callers never read past the record.
    function automatic slot_t get_slot(input logic [PATH_W-1:0] path, input logic [3:0] idx);
        slot_t s;
        s = '0;
        if (int'(idx) < SLOT_COUNT)
            s = slot_t'(path[int'(idx)*SLOT_W +: SLOT_W]);
        return s;
    endfunction

endpackage

// File: rtl/path_replayer_if.sv
// Control, record image and motor/status outputs of the path replayer.
interface path_replayer_if;
    import path_pkg::*;

    logic              start;
    logic              abort;
    logic [PATH_W-1:0] path_data;
    logic [3:0]        entry_cnt;
    logic              M1;
    logic              M2;
    logic              busy;
    logic              done;
    logic [3:0]        cur_slot;
    logic              err;

    modport master (
        output start, abort, path_data, entry_cnt,
        input  M1, M2, busy, done, cur_slot, err
    );

    modport slave (
        input  start, abort, path_data, entry_cnt,
        output M1, M2, busy, done, cur_slot, err
    );
endinterface

// File: rtl/replay_tick_timer.sv
// Cycle prescaler plus 4-bit tick down-counter; expire flags the last cycle of the loaded duration.
// A loaded count of 0 expires immediately (one-cycle hold); N>0 expires after N*TICK_CYCLES cycles.
module replay_tick_timer #(
    parameter int TICK_CYCLES = 7644
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] load_ticks,
    output logic       expire
);
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_MAX = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cyc;
    logic [3:0]    tick_rem;
    logic          wrap;

    assign wrap   = (cyc == CYC_MAX);
    assign expire = en && ((tick_rem == 4'd0) || (tick_rem == 4'd1 && wrap));

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc      <= '0;
            tick_rem <= '0;
        end else if (load) begin
            cyc      <= '0;
            tick_rem <= load_ticks;
        end else if (en) begin
            if (wrap) begin
                cyc <= '0;
                if (tick_rem != 4'd0)
                    tick_rem <= tick_rem - 4'd1;
            end else begin
                cyc <= cyc + 1'b1;
            end
        end
    end
endmodule

// File: rtl/path_replayer.sv
// Replays a recorded motor path oldest-first with recorded timing; outputs registered, 1-cycle start latency.
// Optional marker-bit format check enabled by defining PATH_CHECK_EN.
module path_replayer
    import path_pkg::*;
#(
    parameter int TICK_CYCLES     = 7644,
    parameter int LAST_HOLD_TICKS = 4
) (
    input  logic           clk,
    input  logic           rst,
    path_replayer_if.slave bus
);
    localparam logic [3:0] LAST_T = 4'(LAST_HOLD_TICKS);

    state_t            state;
    logic [PATH_W-1:0] snap;
    logic [3:0]        cur_slot;
    logic [1:0]        mot;
    logic              busy;
    logic              done;
    logic              err;

    logic [3:0] next_slot;
    slot_t      first_s, prime_s, next_s, reload_s;
    logic       mark_bad;
    logic       expire;
    logic       tmr_load;
    logic [3:0] tmr_ticks;

    assign next_slot = cur_slot - 4'd1;
    assign first_s   = get_slot(bus.path_data, bus.entry_cnt - 4'd1);
    assign prime_s   = get_slot(bus.path_data, bus.entry_cnt - 4'd2);
    assign next_s    = get_slot(snap, next_slot);
    assign reload_s  = get_slot(snap, next_slot - 4'd1);

`ifdef PATH_CHECK_EN
    always_comb begin
        mark_bad = 1'b0;
        for (int k = 0; k < SLOT_COUNT; k++)
            if (k < int'(bus.entry_cnt))
                mark_bad = mark_bad | bus.path_data[k*SLOT_W + MARK_BIT];
    end
`else
    assign mark_bad = 1'b0;
`endif

    // Slot k's ticks field times slot k+1, so each load looks one slot ahead of the one being driven.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_ticks = LAST_T;
        if (!bus.abort) begin
            if (state == ST_IDLE && bus.start && !mark_bad && bus.entry_cnt != 4'd0) begin
                tmr_load = 1'b1;
                if (bus.entry_cnt != 4'd1)
                    tmr_ticks = prime_s.ticks;
            end else if (state == ST_RUN && expire) begin
                tmr_load = 1'b1;
                if (next_slot != 4'd0)
                    tmr_ticks = reload_s.ticks;
            end
        end
    end

    replay_tick_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .en         (state == ST_RUN || state == ST_LAST),
        .load       (tmr_load),
        .load_ticks (tmr_ticks),
        .expire     (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            snap     <= '0;
            cur_slot <= '0;
            mot      <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else if (bus.abort) begin
            state    <= ST_IDLE;
            cur_slot <= '0;
            mot      <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        err <= mark_bad;
                        if (mark_bad || bus.entry_cnt == 4'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            snap     <= bus.path_data;
                            cur_slot <= bus.entry_cnt - 4'd1;
                            mot      <= {first_s.m2, first_s.m1};
                            busy     <= 1'b1;
                            state    <= (bus.entry_cnt == 4'd1) ? ST_LAST : ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (expire) begin
                        cur_slot <= next_slot;
                        mot      <= {next_s.m2, next_s.m1};
                        if (next_slot == 4'd0)
                            state <= ST_LAST;
                    end
                end
                ST_LAST: begin
                    if (expire) begin
                        mot   <= 2'b00;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.M1       = mot[0];
    assign bus.M2       = mot[1];
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.cur_slot = cur_slot;
    assign bus.err      = err;
endmodule
